encoder_8to3_scan: RTL and testbench
====================================

# encoder_8to3_scan

Sequential 8-to-3 encoder, the inverse of the team's one-hot 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per handshake, in priority order. It sits between request-collecting logic, such as interrupt or arbitration vectors, and downstream consumers that operate on binary indices.

## Interface
- LSB_FIRST, 1, scan order: 1 = lowest set bit first, 0 = highest set bit first
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_vec is valid
- in_ready  out  1  block can accept a vector
- in_vec  in  8  request vector; bit i set means index i is requested
- out_valid  out  1  out_idx/out_last are valid
- out_ready  in  1  consumer accepts the current index
- out_idx  out  3  binary index of the current set bit
- out_last  out  1  current index is the final one of the vector
- zero_drop  out  1  single-cycle pulse: an all-zero vector was accepted and discarded
- busy  out  1  a vector is being scanned (state SCAN)

## Operation
- **States:** IDLE and SCAN. Internal register `pending[7:0]` holds the bits not yet emitted.
- **IDLE:**
  - in_ready=1, out_valid=0.
  - When in_valid and in_ready are both high and in_vec is nonzero: load pending=in_vec, go to SCAN.
  - When in_valid and in_ready are both high and in_vec is zero: stay in IDLE and pulse zero_drop for the next cycle.
- **SCAN:**
  - in_ready=0, out_valid=1, busy=1.
  - out_idx = position of the lowest set bit of pending, or the highest set bit when LSB_FIRST=0.
  - out_last = 1 when pending has exactly one bit set.
  - When out_valid and out_ready are both high: clear bit out_idx in pending. If out_last=1, go to IDLE.
- **Output stability:** out_idx and out_last are decoded from registers only, with no combinational path from any input. They hold stable while out_valid=1 and out_ready=0.
- **in_vec sampling:** in_vec is sampled only at acceptance. Changes to in_vec during SCAN are ignored.
- **No pipelining:** a new vector is never accepted in the same cycle that the last index is handshaken.
- **Reset values** (applied immediately on rst_n low):
  - state = IDLE, pending = 0
  - in_ready = 1
  - out_valid = 0, out_idx = 0, out_last = 0
  - zero_drop = 0, busy = 0
- **Reset mid-SCAN:** remaining indices are discarded and no further out_valid is produced. On rst_n release the block is in IDLE.

## Timing
- **First-index latency:** a vector is accepted at edge N; its first index is valid in the cycle after edge N.
- **Throughput:** a vector with k set bits needs k output cycles when out_ready is held high. After the last handshake there is one IDLE cycle before the next acceptance. Per vector this totals k+1 cycles, k ≥ 1.
- **zero_drop:** asserts for exactly one cycle, the cycle after a zero vector is accepted. in_ready stays high throughout.
- **Backpressure:** any number of stall cycles is allowed. pending and state are unchanged while out_ready=0.

## Structure
- **Shared package `encoder_pkg`:**
  - `state_t` enum {IDLE, SCAN}
  - localparams VEC_W=8 and IDX_W=3
- **Sub-module `pri_enc8`:** combinational lowest-set-bit finder, inputs vec[7:0], outputs idx[2:0] and `any`.
  - MSB-first order reuses the same sub-module on the bit-reversed vector, with the resulting index mapped back as 7-idx.
  - The onehot flag for out_last is computed as pending & (pending-1) == 0.

## Test plan
- **Scan order:** LSB_FIRST=1, in_vec=8'hA5, out_ready=1 → out_idx 0,2,5,7 on four consecutive cycles; out_last only with 7; in_ready=1 the cycle after.
- **Backpressure:** in_vec=8'h81, out_ready=0 for 3 cycles → out_idx=0 and out_valid=1 held stable; then out_ready=1 → 0 then 7 (out_last=1).
- **Zero vector:** in_vec=8'h00 accepted → zero_drop=1 for one cycle, out_valid never asserts, busy=0, in_ready stays 1.
- **One-hot sweep:** 8'h01…8'h80 each sent singly → exactly one index equal to the bit position, with out_last=1. Re-decoding each index to one-hot reproduces in_vec.
- **MSB-first:** LSB_FIRST=0, in_vec=8'hFF → indices 7,6,…,0 over 8 cycles; out_last only with 0.
- **Reset mid-SCAN:** after the first index of 8'h3C, drop rst_n asynchronously mid-cycle → outputs take reset values immediately. After release: in_ready=1, no residual indices, and the next vector 8'h02 yields idx 1 with out_last=1.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and widths for the sequential 8-to-3 scanning encoder.
package encoder_pkg;

  localparam int unsigned VEC_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/pri_enc8.sv
// Combinational lowest-set-bit finder over an 8-bit vector.
module pri_enc8
  import encoder_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Descending walk so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/encoder_8to3_scan.sv
// Accepts a request vector and emits the index of each set bit, one per handshake,
// in LSB-first or MSB-first order.
module encoder_8to3_scan
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_drop,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d;
  logic             zero_drop_q, zero_drop_d;

  logic [VEC_W-1:0] scan_vec;
  logic [IDX_W-1:0] enc_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             enc_any;
  logic             scanning;
  logic             onehot;

  // MSB-first reuses the LSB finder on the bit-reversed vector.
  if (LSB_FIRST) begin : g_lsb
    assign scan_vec = pending_q;
    assign scan_idx = enc_idx;
  end else begin : g_msb
    for (genvar i = 0; i < VEC_W; i++) begin : g_rev
      assign scan_vec[i] = pending_q[VEC_W-1-i];
    end
    assign scan_idx = IDX_W'(VEC_W - 1) - enc_idx;
  end

  pri_enc8 u_pri_enc8 (
    .vec (scan_vec),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign scanning  = (state_q == SCAN);
  assign onehot    = ((pending_q & (pending_q - VEC_W'(1))) == '0);

  // Outputs come only from registers so they stay stable under backpressure.
  assign in_ready  = ~scanning;
  assign out_valid = scanning;
  assign busy      = scanning;
  assign out_idx   = scanning ? scan_idx : '0;
  assign out_last  = scanning & enc_any & onehot;
  assign zero_drop = zero_drop_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = SCAN;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(VEC_W'(1) << out_idx);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule

// File: tb/tb_encoder_8to3_scan.sv
// Directed bench: one LSB-first and one MSB-first instance driven by shared inputs.
module tb_encoder_8to3_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       out_ready = 1'b0;

  logic       l_in_ready, l_out_valid, l_out_last, l_zero_drop, l_busy;
  logic [2:0] l_out_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_zero_drop, m_busy;
  logic [2:0] m_out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encoder_8to3_scan #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (l_in_ready),
    .in_vec    (in_vec),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .out_idx   (l_out_idx),
    .out_last  (l_out_last),
    .zero_drop (l_zero_drop),
    .busy      (l_busy)
  );

  encoder_8to3_scan #(.LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .in_vec    (in_vec),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_idx   (m_out_idx),
    .out_last  (m_out_last),
    .zero_drop (m_zero_drop),
    .busy      (m_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " l_in_ready"}, 32'(l_in_ready), 32'd1);
    check_eq({tag, " l_out_valid"}, 32'(l_out_valid), 32'd0);
    check_eq({tag, " l_busy"}, 32'(l_busy), 32'd0);
    check_eq({tag, " m_in_ready"}, 32'(m_in_ready), 32'd1);
    check_eq({tag, " m_out_valid"}, 32'(m_out_valid), 32'd0);
  endtask

  // Present a vector for one edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  logic [7:0] onehot_vec;

  initial begin
    // Reset values, applied asynchronously.
    #2 rst_n = 1'b0;
    #1;
    check_idle("reset");
    check_eq("reset l_out_idx", 32'(l_out_idx), 32'd0);
    check_eq("reset m_out_idx", 32'(m_out_idx), 32'd0);
    check_eq("reset l_out_last", 32'(l_out_last), 32'd0);
    check_eq("reset l_zero_drop", 32'(l_zero_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("post-reset");

    // LSB-first scan of A5; in_vec changes during SCAN are ignored.
    out_ready = 1'b1;
    send(8'hA5);
    in_vec = 8'hFF;
    check_eq("a5 valid", 32'(l_out_valid), 32'd1);
    check_eq("a5 busy", 32'(l_busy), 32'd1);
    check_eq("a5 in_ready", 32'(l_in_ready), 32'd0);
    check_eq("a5 idx0", 32'(l_out_idx), 32'd0);
    check_eq("a5 last0", 32'(l_out_last), 32'd0);
    check_eq("a5 msb idx0", 32'(m_out_idx), 32'd7);
    step();
    check_eq("a5 idx1", 32'(l_out_idx), 32'd2);
    check_eq("a5 last1", 32'(l_out_last), 32'd0);
    step();
    check_eq("a5 idx2", 32'(l_out_idx), 32'd5);
    check_eq("a5 last2", 32'(l_out_last), 32'd0);
    step();
    check_eq("a5 idx3", 32'(l_out_idx), 32'd7);
    check_eq("a5 last3", 32'(l_out_last), 32'd1);
    check_eq("a5 msb idx3", 32'(m_out_idx), 32'd0);
    check_eq("a5 msb last3", 32'(m_out_last), 32'd1);
    step();
    check_idle("a5 done");

    // Backpressure holds the first index of 81.
    out_ready = 1'b0;
    send(8'h81);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp valid", 32'(l_out_valid), 32'd1);
      check_eq("bp idx", 32'(l_out_idx), 32'd0);
      check_eq("bp last", 32'(l_out_last), 32'd0);
      step();
    end
    check_eq("bp idx hold", 32'(l_out_idx), 32'd0);
    out_ready = 1'b1;
    step();
    check_eq("bp idx next", 32'(l_out_idx), 32'd7);
    check_eq("bp last next", 32'(l_out_last), 32'd1);
    step();
    check_idle("bp done");

    // Zero vector is dropped with a one-cycle pulse.
    send(8'h00);
    check_eq("zero pulse", 32'(l_zero_drop), 32'd1);
    check_eq("zero pulse msb", 32'(m_zero_drop), 32'd1);
    check_idle("zero");
    step();
    check_eq("zero pulse end", 32'(l_zero_drop), 32'd0);
    check_idle("zero after");

    // One-hot sweep: single index equal to the bit position, re-decodes to the input.
    for (int b = 0; b < 8; b++) begin
      send(8'(1 << b));
      check_eq("sweep idx", 32'(l_out_idx), 32'(b));
      check_eq("sweep last", 32'(l_out_last), 32'd1);
      check_eq("sweep msb idx", 32'(m_out_idx), 32'(b));
      check_eq("sweep msb last", 32'(m_out_last), 32'd1);
      onehot_vec = 8'd1 << l_out_idx;
      check_eq("sweep redecode", 32'(onehot_vec), 32'(1 << b));
      step();
      check_eq("sweep idle", 32'(l_out_valid), 32'd0);
    end

    // FF: MSB-first yields 7..0, LSB-first yields 0..7.
    send(8'hFF);
    for (int j = 0; j < 8; j++) begin
      check_eq("ff msb idx", 32'(m_out_idx), 32'(7 - j));
      check_eq("ff msb last", 32'(m_out_last), 32'(j == 7));
      check_eq("ff lsb idx", 32'(l_out_idx), 32'(j));
      check_eq("ff msb valid", 32'(m_out_valid), 32'd1);
      step();
    end
    check_idle("ff done");

    // Asynchronous reset in the middle of a scan of 3C.
    send(8'h3C);
    check_eq("rst first idx", 32'(l_out_idx), 32'd2);
    step();
    check_eq("rst second idx", 32'(l_out_idx), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst async");
    check_eq("rst l_out_idx", 32'(l_out_idx), 32'd0);
    check_eq("rst l_out_last", 32'(l_out_last), 32'd0);
    check_eq("rst m_out_idx", 32'(m_out_idx), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("rst release");
    step();
    check_idle("rst no residue");
    send(8'h02);
    check_eq("rst next idx", 32'(l_out_idx), 32'd1);
    check_eq("rst next last", 32'(l_out_last), 32'd1);
    check_eq("rst next valid", 32'(l_out_valid), 32'd1);
    step();
    check_idle("rst next done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
